// File: rtl/aes_pkg.sv
// Shared AES constants, state type and byte-position helper.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NB      = 4;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  // Byte k = col*4 + row occupies [127-8k -: 8]; return its lsb position.
  function automatic int byte_lsb(input int row, input int col);
    return AES_STATE_W - AES_BYTE_W * (col * AES_NB + row + 1);
  endfunction

endpackage

// File: rtl/aes_row_rotate.sv
// Combinational ShiftRows permutation: fwd=0 rotates row r right by r (inverse),
// fwd=1 rotates row r left by r (forward).
module aes_row_rotate
  import aes_pkg::*;
(
  input  aes_state_t in_state,
  input  logic       fwd,
  output aes_state_t out_state
);

  for (genvar r = 0; r < AES_NB; r++) begin : g_row
    for (genvar c = 0; c < AES_NB; c++) begin : g_col
      assign out_state[byte_lsb(r, c) +: AES_BYTE_W] = fwd
        ? in_state[byte_lsb(r, (c + r) % AES_NB) +: AES_BYTE_W]
        : in_state[byte_lsb(r, (c + AES_NB - r) % AES_NB) +: AES_BYTE_W];
    end
  end

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows pipeline stage with valid/ready flow control.
// Optional macro INV_SHIFT_ROWS_FWD_EN adds a fwd port selecting forward ShiftRows.
module inv_shift_rows
  import aes_pkg::*;
#(
  parameter int REG_OUT = 1
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_SHIFT_ROWS_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  // Handshake: a beat moves on a rising edge when valid && ready; a held
  // valid keeps its data stable until the matching ready is seen.

  logic       dir;
  aes_state_t perm;

`ifdef INV_SHIFT_ROWS_FWD_EN
  assign dir = fwd;
`else
  assign dir = 1'b0;
`endif

  aes_row_rotate u_rot (
    .in_state  (in_state),
    .fwd       (dir),
    .out_state (perm)
  );

  if (REG_OUT != 0) begin : g_reg
    logic       valid_q;
    aes_state_t state_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        state_q <= '0;
      end else if (in_valid && in_ready) begin
        valid_q <= 1'b1;
        state_q <= perm;
      end else if (out_ready) begin
        // Drained with nothing new: data is kept, only valid drops.
        valid_q <= 1'b0;
      end
    end
  end else begin : g_comb
    logic unused_rst;
    assign unused_rst = rst;
    assign out_valid  = in_valid;
    assign in_ready   = out_ready;
    assign out_state  = perm;
  end

endmodule

// File: tb/tb_inv_shift_rows.sv
// Directed bench for inv_shift_rows (REG_OUT=1) with a byte-map scoreboard.
module tb_inv_shift_rows;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         fwd;

  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  localparam int INV_MAP[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  localparam int FWD_MAP[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  always #5 clk = ~clk;

  inv_shift_rows #(.REG_OUT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_SHIFT_ROWS_FWD_EN
    .fwd       (fwd),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  function automatic logic [127:0] model(input logic [127:0] s, input logic f);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      int src;
      src = f ? FWD_MAP[k] : INV_MAP[k];
      r[127-8*k -: 8] = s[127-8*src -: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output beats are popped and compared; accepted inputs are pushed.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL spurious_out: got beat %h expected none", out_state);
        end
        if (exp_q.size() != 0) check("sb_out", out_state, exp_q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_state, fwd));
    end
  end

  initial begin
    int p0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; fwd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Known-answer vectors
    out_ready = 1'b1; in_valid = 1'b1;
    in_state = 128'h325a9834883107a83137f68de04330a2;
    tick();
    in_valid = 1'b0;
    check("kat1_valid", out_valid, 1);
    check("kat1_state", out_state, 128'h3243f6a8885a308d313198a2e0370734);
    tick();
    in_valid = 1'b1;
    in_state = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    in_valid = 1'b0;
    check("kat2_state", out_state, 128'h000d0a0704010e0b0805020f0c090603);
    tick();
    check("idle_valid", out_valid, 0);

    // Backpressure: one beat held for 5 cycles, then a single drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rand_state();
    p0 = pops;
    begin
      logic [127:0] held;
      held = model(in_state, 1'b0);
      tick();
      in_state = rand_state();
      for (int i = 0; i < 5; i++) begin
        tick();
        check("bp_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_state", out_state, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain_count", pops, p0 + 1);
    check("bp_drained_valid", out_valid, 0);
    tick();
    check("bp_one_beat", pops, p0 + 1);

    // Back-to-back: four beats, no bubbles
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_state = rand_state();
      check("b2b_in_ready", in_ready, 1);
      tick();
      check("b2b_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_count", pops, p0 + 4);
    check("b2b_idle", out_valid, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_state  = rand_state();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset between edges while holding a beat
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rand_state();
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_state", out_state, 0);
    check("ar_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ar_post_valid", out_valid, 0);

`ifdef INV_SHIFT_ROWS_FWD_EN
    fwd = 1'b1; in_valid = 1'b1;
    in_state = 128'h3243f6a8885a308d313198a2e0370734;
    tick();
    in_state = 128'h000102030405060708090a0b0c0d0e0f;
    check("fwd1_state", out_state, 128'h325a9834883107a83137f68de04330a2);
    tick();
    in_valid = 1'b0;
    check("fwd2_state", out_state, 128'h00050a0f04090e03080d02070c01060b);
    tick();
    fwd = 1'b0;
`endif

    tick();
    check("queue_drained", 128'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows.md
Name: inv_shift_rows

Overview:
AES InvShiftRows stage for the decryption datapath. Cyclically right-rotates row r of the 4x4 byte state by r positions.
Wrapped as a single-register pipeline stage with valid/ready flow control. Sits between the AddRoundKey/InvMixColumns and InvSubBytes stages of the inverse cipher round.

Parameters:
REG_OUT, 1, 1 = registered output stage (1-cycle latency); 0 = purely combinational pass-through (valid/ready/data wired through, no state).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_state valid
in_ready  output  1  stage can accept in_state this cycle
in_state  input  128  AES state, byte k = in_state[127-8k -: 8], k = 0..15
out_valid  output  1  out_state valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  permuted state, same byte numbering

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- State layout is column-major: byte k is row r = k mod 4, column c = k div 4.
- Inverse mapping: out(r,c) = in(r,(c - r) mod 4).
  - Row 0 unchanged.
  - Row 1 rotated right by 1.
  - Row 2 rotated right by 2.
  - Row 3 rotated right by 3.
- Explicit byte map (out byte <- in byte): 0<-0, 1<-13, 2<-10, 3<-7, 4<-4, 5<-1, 6<-14, 7<-11, 8<-8, 9<-5, 10<-2, 11<-15, 12<-12, 13<-9, 14<-6, 15<-3.
- Pure permutation: no arithmetic, no data-dependent behaviour.
- REG_OUT=1:
  - in_ready = !out_valid || out_ready.
  - A transfer occurs on a clk edge when in_valid && in_ready; out_state <= permute(in_state), out_valid <= 1.
  - If out_valid && out_ready and no new transfer, out_valid <= 0. out_state holds its last value.
  - Simultaneous drain and fill: new data loaded, out_valid stays 1. Full throughput of one state per cycle.
  - While out_valid && !out_ready: out_state and out_valid hold stable; in_ready = 0.
- Reset (any time, including mid-transfer): out_valid = 0 and out_state = 0 immediately. in_ready = 1 after reset.
- REG_OUT=0: out_valid = in_valid, in_ready = out_ready, out_state = permute(in_state) combinationally. rst unused.
- No X propagation: out_state is defined at all times after reset.

Optional Feature:
INV_SHIFT_ROWS_FWD_EN
- Defined: adds input port fwd (1 bit), sampled with in_state on transfer.
  - fwd=1 applies the forward ShiftRows mapping, out(r,c) = in(r,(c + r) mod 4).
  - fwd=0 applies the inverse mapping.
  - Lets one instance serve both encryption and decryption rounds.
- Undefined: no fwd port; inverse mapping only.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W = 128, AES_BYTE_W = 8, AES_NB = 4.
  - Typedef aes_state_t for the 128-bit state.
  - Function for byte index (row, col) -> bit offset.
- One sub-module: aes_row_rotate, a combinational permutation taking in_state and a direction bit. Instantiated once; the top level holds only the pipeline register and handshake.

Test Plan:
- REG_OUT=1, in_state = 325a9834883107a83137f68de04330a2, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_state = 3243f6a8885a308d313198a2e0370734.
- in_state = 000102030405060708090a0b0c0d0e0f -> out_state = 000d0a0704010e0b0805020f0c090603.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; out_state and out_valid stable for 5 cycles; releasing out_ready drains exactly one beat.
- Back-to-back: 4 consecutive states with out_ready=1 -> 4 outputs on consecutive cycles, in order, no bubbles.
- Reset asserted asynchronously between clock edges while out_valid=1 -> out_valid=0 and out_state=0 before the next edge; in_ready=1.
- With INV_SHIFT_ROWS_FWD_EN:
  - fwd=1, in_state = 3243f6a8885a308d313198a2e0370734 -> out_state = 325a9834883107a83137f68de04330a2.
  - fwd=1, in_state = 000102...0f -> out_state = 00050a0f04090e03080d02070c01060b.
